// File: rtl/cipher_pkg.sv
// cipher_pkg: shared mode/state encodings and defaults for the cipher stream engine
package cipher_pkg;
  typedef enum logic [1:0] {MODE_PASS = 2'b00, MODE_CAESAR = 2'b01, MODE_VIG = 2'b10, MODE_AUTO = 2'b11} mode_t;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_DRAIN = 2'b10} state_t;
  localparam int DEFAULT_ALPHA = 26;
endpackage

// File: rtl/cipher_mod_alu.sv
// cipher_mod_alu: combinational modular add/subtract over an ALPHA-symbol alphabet
module cipher_mod_alu
  import cipher_pkg::*;
#(
  parameter int SYM_W = 5,
  parameter int ALPHA = DEFAULT_ALPHA
) (
  input  logic [SYM_W-1:0] in_sym,
  input  logic [SYM_W-1:0] k,
  input  logic             decode,
  output logic [SYM_W-1:0] out,
  output logic             in_range
);
  localparam logic [SYM_W:0] A = ALPHA[SYM_W:0];
  logic [SYM_W:0] sum, dif, sum_w, dif_w;
  always_comb begin
    sum = {1'b0, in_sym} + {1'b0, k};
    dif = {1'b0, in_sym} - {1'b0, k};
    sum_w = sum >= A ? sum - A : sum;
    dif_w = dif[SYM_W] ? dif + A : dif;
    in_range = {1'b0, in_sym} < A;
    out = !in_range ? in_sym : decode ? dif_w[SYM_W-1:0] : sum_w[SYM_W-1:0];
  end
endmodule

// File: rtl/cipher_stream_engine.sv
// cipher_stream_engine: streaming pass/Caesar/Vigenere/autokey codec with valid/ready on both sides
module cipher_stream_engine
  import cipher_pkg::*;
#(
  parameter int SYM_W = 5,
  parameter int ALPHA = DEFAULT_ALPHA,
  parameter int KEY_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [1:0]                     mode,
  input  logic                           decode,
  input  logic                           key_wr,
  input  logic [SYM_W-1:0]               key_sym,
  input  logic                           key_clr,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [SYM_W-1:0]               in_sym,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SYM_W-1:0]               out_sym,
  output logic                           busy,
  output logic                           err,
  output logic [$clog2(KEY_DEPTH+1)-1:0] key_len
);
  localparam int LW = $clog2(KEY_DEPTH + 1);
  localparam int IW = KEY_DEPTH > 1 ? $clog2(KEY_DEPTH) : 1;
  localparam logic [SYM_W:0] A = ALPHA[SYM_W:0];
  localparam logic [LW-1:0] KD = KEY_DEPTH[LW-1:0];
  state_t state;
  mode_t mode_q;
  logic dec_q, warm, xfer, last, alu_ok;
  logic [SYM_W-1:0] key [KEY_DEPTH];
  logic [SYM_W-1:0] hist [KEY_DEPTH];
  logic [SYM_W-1:0] k, alu_out, plain;
  logic [IW-1:0] idx;
  // idx doubles as the history pointer: both wrap at key_len, so hist[idx] is the plaintext key_len transfers back
  always_comb begin
    k = mode_q == MODE_PASS ? '0 : mode_q == MODE_CAESAR ? key[0] : (mode_q == MODE_AUTO && warm) ? hist[idx] : key[idx];
    in_ready = state == S_RUN && (!out_valid || out_ready);
    xfer = in_valid && in_ready;
    last = LW'(idx) == key_len - LW'(1);
    plain = dec_q ? alu_out : in_sym;
    busy = state != S_IDLE;
  end
  cipher_mod_alu #(.SYM_W(SYM_W), .ALPHA(ALPHA)) u_alu (
    .in_sym(in_sym), .k(k), .decode(dec_q), .out(alu_out), .in_range(alu_ok)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      mode_q <= MODE_PASS;
      dec_q <= 1'b0;
      warm <= 1'b0;
      idx <= '0;
      key_len <= '0;
      err <= 1'b0;
      out_valid <= 1'b0;
      out_sym <= '0;
      for (int i = 0; i < KEY_DEPTH; i++) begin
        key[i] <= '0;
        hist[i] <= '0;
      end
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_sym <= alu_out;
      end else if (out_ready) out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (key_clr) begin
            key_len <= '0;
            err <= 1'b0;
          end else if (key_wr) begin
            if ({1'b0, key_sym} < A && key_len < KD) begin
              key[key_len[IW-1:0]] <= key_sym;
              key_len <= key_len + LW'(1);
            end else err <= 1'b1;
          end
          if (start) begin
            if (mode != MODE_PASS && key_len == '0) err <= 1'b1;
            else begin
              state <= S_RUN;
              mode_q <= mode_t'(mode);
              dec_q <= decode;
              idx <= '0;
              warm <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (xfer) begin
            if (!alu_ok) err <= 1'b1;
            else if (mode_q == MODE_VIG || mode_q == MODE_AUTO) begin
              hist[idx] <= plain;
              idx <= last ? '0 : idx + IW'(1);
              if (last) warm <= 1'b1;
            end
          end
          if (stop) state <= S_DRAIN;
        end
        S_DRAIN: if (!out_valid || out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cipher_stream_engine.sv
// tb_cipher_stream_engine: vector table, corner-case sequences and random runs against a reference model
module tb_cipher_stream_engine;
  import cipher_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] mode = '0;
  logic decode = 1'b0, key_wr = 1'b0, key_clr = 1'b0, start = 1'b0, stop = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [4:0] key_sym = '0, in_sym = '0;
  logic in_ready, out_valid, busy, err;
  logic [4:0] out_sym;
  logic [3:0] key_len;
  int checks = 0, errors = 0;
  int kq[$];
  int expq[$];
  int rk[8];
  int rl, rmode, rj;
  bit rdec, roob;
  int rplain[$];
  typedef struct {int m; bit d; int k; int s; int e;} vec_t;
  vec_t vt[10];

  always #5 clk = ~clk;

  cipher_stream_engine dut (
    .clk(clk), .reset(reset), .mode(mode), .decode(decode), .key_wr(key_wr), .key_sym(key_sym),
    .key_clr(key_clr), .start(start), .stop(stop), .in_valid(in_valid), .in_ready(in_ready),
    .in_sym(in_sym), .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
    .busy(busy), .err(err), .key_len(key_len)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key();
    key_clr = 1'b1;
    tick();
    key_clr = 1'b0;
    foreach (kq[i]) begin
      key_wr = 1'b1;
      key_sym = 5'(kq[i]);
      tick();
    end
    key_wr = 1'b0;
  endtask

  task automatic run(input int m, input bit d);
    mode = 2'(m);
    decode = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int s, input int e, input string nm);
    int n = 0;
    in_valid = 1'b1;
    in_sym = 5'(s);
    out_ready = 1'b1;
    #1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) check({nm, "_ready_timeout"}, 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check({nm, "_valid"}, 32'(out_valid), 1);
    check(nm, 32'(out_sym), 32'(e));
  endtask

  task automatic finish_run();
    stop = 1'b1;
    out_ready = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    check("idle_after_stop", 32'(busy), 0);
  endtask

  function automatic int model(input int s);
    int kk, r;
    if (s >= 26) begin
      roob = 1'b1;
      return s;
    end
    kk = rmode == 0 ? 0 : rmode == 1 ? rk[0] : rmode == 2 ? rk[rj % rl] : (rj < rl ? rk[rj] : rplain[rj - rl]);
    r = rdec ? (s - kk + 26) % 26 : (s + kk) % 26;
    rplain.push_back(rdec ? r : s);
    rj++;
    return r;
  endfunction

  task automatic step(input bit v, input int s, input bit r);
    in_valid = v;
    in_sym = 5'(s);
    out_ready = r;
    #1;
    check("rand_out_valid", 32'(out_valid), 32'(expq.size() != 0));
    check("rand_in_ready", 32'(in_ready), 32'(expq.size() == 0 || r));
    if (out_valid && out_ready) begin
      if (expq.size() == 0) check("rand_extra_out", 32'(out_valid), 0);
      else check("rand_out", 32'(out_sym), 32'(expq.pop_front()));
    end
    if (in_valid && in_ready) expq.push_back(model(s));
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1, 0, 3, 0, 3};
    vt[1] = '{1, 0, 3, 1, 4};
    vt[2] = '{1, 0, 3, 25, 2};
    vt[3] = '{1, 1, 3, 2, 25};
    vt[4] = '{1, 1, 3, 0, 23};
    vt[5] = '{1, 0, 25, 1, 0};
    vt[6] = '{0, 0, 9, 17, 17};
    vt[7] = '{2, 0, 5, 24, 3};
    vt[8] = '{2, 1, 5, 3, 24};
    vt[9] = '{3, 1, 4, 11, 7};
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_sym", 32'(out_sym), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_key_len", 32'(key_len), 0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      kq = {vt[i].k};
      load_key();
      run(vt[i].m, vt[i].d);
      send(vt[i].s, vt[i].e, $sformatf("vec%0d", i));
      finish_run();
    end
    kq = {3};
    load_key();
    run(1, 0);
    send(0, 3, "caesar_0");
    send(1, 4, "caesar_1");
    send(25, 2, "caesar_25");
    finish_run();
    kq = {1, 2, 3};
    load_key();
    check("vig_key_len", 32'(key_len), 3);
    run(2, 0);
    send(0, 1, "vig_enc0");
    send(0, 2, "vig_enc1");
    send(0, 3, "vig_enc2");
    send(0, 1, "vig_enc3");
    finish_run();
    run(2, 1);
    send(1, 0, "vig_dec0");
    send(2, 0, "vig_dec1");
    send(3, 0, "vig_dec2");
    send(1, 0, "vig_dec3");
    finish_run();
    kq = {4};
    load_key();
    run(3, 0);
    send(7, 11, "auto0");
    send(4, 11, "auto1");
    send(11, 15, "auto2");
    finish_run();
    kq = {3};
    load_key();
    run(1, 0);
    in_valid = 1'b1;
    in_sym = 5'd5;
    out_ready = 1'b0;
    tick();
    check("bp_first", 32'(out_sym), 8);
    in_sym = 5'd6;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_hold_sym", 32'(out_sym), 8);
      check("bp_hold_valid", 32'(out_valid), 1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("bp_second", 32'(out_sym), 9);
    check("bp_second_valid", 32'(out_valid), 1);
    tick();
    check("bp_empty", 32'(out_valid), 0);
    finish_run();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    key_wr = 1'b1;
    key_sym = 5'd26;
    tick();
    key_wr = 1'b0;
    check("keywr_oob_err", 32'(err), 1);
    check("keywr_oob_len", 32'(key_len), 0);
    key_clr = 1'b1;
    tick();
    key_clr = 1'b0;
    check("key_clr_err", 32'(err), 0);
    run(2, 0);
    check("empty_start_busy", 32'(busy), 0);
    check("empty_start_err", 32'(err), 1);
    kq = {0, 1, 2, 3, 4, 5, 6, 7, 8};
    load_key();
    check("key_full_len", 32'(key_len), 8);
    check("key_full_err", 32'(err), 1);
    kq = {3};
    load_key();
    run(1, 0);
    send(30, 30, "oob_sym");
    check("oob_sym_err", 32'(err), 1);
    finish_run();
    kq = {3};
    load_key();
    run(1, 0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_sym = 5'd1;
    tick();
    in_valid = 1'b0;
    check("drain_pending", 32'(out_sym), 4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("drain_busy", 32'(busy), 1);
    check("drain_in_ready", 32'(in_ready), 0);
    tick();
    check("drain_hold", 32'(busy), 1);
    check("drain_hold_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    check("drain_idle", 32'(busy), 0);
    check("drain_idle_valid", 32'(out_valid), 0);
    run(1, 0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_sym = 5'd2;
    tick();
    in_valid = 1'b0;
    check("rrun_pending", 32'(out_valid), 1);
    reset = 1'b1;
    tick();
    check("rrun_out_valid", 32'(out_valid), 0);
    check("rrun_out_sym", 32'(out_sym), 0);
    check("rrun_busy", 32'(busy), 0);
    check("rrun_in_ready", 32'(in_ready), 0);
    check("rrun_err", 32'(err), 0);
    check("rrun_key_len", 32'(key_len), 0);
    reset = 1'b0;
    tick();
    for (int r = 0; r < 8; r++) begin
      rl = $urandom_range(1, 8);
      kq = {};
      for (int i = 0; i < rl; i++) begin
        rk[i] = $urandom_range(0, 25);
        kq.push_back(rk[i]);
      end
      rmode = r % 4;
      rdec = 1'($urandom_range(0, 1));
      rj = 0;
      roob = 1'b0;
      rplain.delete();
      expq.delete();
      load_key();
      check("rand_key_len", 32'(key_len), 32'(rl));
      run(rmode, rdec);
      check("rand_busy", 32'(busy), 1);
      for (int c = 0; c < 150; c++)
        step($urandom % 4 != 0, ($urandom % 10 == 0) ? $urandom_range(26, 31) : $urandom_range(0, 25), $urandom % 3 != 0);
      for (int c = 0; c < 3; c++) step(1'b0, 0, 1'b1);
      check("rand_drained", 32'(expq.size()), 0);
      check("rand_err", 32'(err), 32'(roob));
      finish_run();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cipher_stream_engine.md
# cipher_stream_engine

Parametrised successor to the single-character Caesar path: a streaming encode/decode engine with a loadable multi-symbol key, Caesar, Vigenère and autokey modes, and a valid/ready handshake on both sides. It sits between the character source (switch/keyboard front end) and the display/verify logic. It processes one symbol per cycle with one cycle of registered latency, and wraps modulo a configurable alphabet size.

## Interface
- SYM_W, 5: symbol width in bits.
- ALPHA, 26: alphabet size. Legal symbols are 0..ALPHA-1, so 0='a' and 25='z'. Must satisfy ALPHA ≤ 2^SYM_W.
- KEY_DEPTH, 8: maximum key length in symbols.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mode  in  2  cipher mode: 00 pass, 01 Caesar, 10 Vigenère, 11 autokey. Sampled only at start.
- decode  in  1  1 = decode, 0 = encode. Sampled only at start.
- key_wr  in  1  write key_sym at the key write pointer. Honoured only in IDLE.
- key_sym  in  SYM_W  key symbol to write.
- key_clr  in  1  clear the key (length := 0). Honoured only in IDLE.
- start  in  1  pulse. Moves IDLE→RUN.
- stop  in  1  pulse. Moves RUN→DRAIN.
- in_valid, in_ready  in/out  1  input handshake.
- in_sym  in  SYM_W  plaintext or ciphertext symbol.
- out_valid, out_ready  out/in  1  output handshake.
- out_sym  out  SYM_W  result symbol.
- busy  out  1  state ≠ IDLE.
- err  out  1  sticky error flag. Cleared by reset or key_clr.
- key_len  out  $clog2(KEY_DEPTH+1)  number of key symbols currently loaded.

## Operation
- FSM states are IDLE, RUN and DRAIN. Reset enters IDLE.
- IDLE:
  - key_clr has priority over key_wr in the same cycle.
  - key_wr with key_sym < ALPHA and key_len < KEY_DEPTH stores the symbol at index key_len, then increments key_len.
  - A key_wr that is out of range or arrives when the key is full is dropped and sets err.
  - start latches mode and decode, sets key index := 0, and enters RUN. If mode ∈ {01,10,11} and key_len = 0, start is refused (the FSM stays in IDLE) and err is set.
- RUN:
  - in_ready = !out_valid || out_ready.
  - Each transfer (in_valid && in_ready) computes the result and loads the output register.
- Key selection per transfer:
  - 00: no key; the symbol is passed through.
  - 01: always key[0].
  - 10: key[idx]. Then idx := (idx == key_len-1) ? 0 : idx+1.
  - 11: the first key_len symbols use key[idx]. After that, the key is the plaintext symbol from key_len transfers earlier. For encode this is in_sym; for decode it is the produced out_sym. These plaintext symbols are held in a KEY_DEPTH-entry circular history buffer.
- Arithmetic:
  - Encode: s = in_sym + k, computed with width SYM_W+1; if s ≥ ALPHA then s -= ALPHA.
  - Decode: s = in_sym − k; if negative then s += ALPHA.
  - in_sym ≥ ALPHA is passed through unmodified. It sets err and does not advance idx or the autokey history.
- stop in RUN enters DRAIN. In DRAIN, in_ready = 0. DRAIN returns to IDLE when the output register is empty or is being consumed that cycle (out_valid=0, or out_valid && out_ready).
- Simultaneous start and stop: only the transition legal in the current state is taken. start and stop are ignored in DRAIN.
- key_wr and key_clr are ignored while busy.
- Reset mid-stream discards the pending output.

## Timing
- Reset values:
  - state = IDLE, out_valid = 0, out_sym = 0, in_ready = 0, busy = 0, err = 0, key_len = 0.
  - idx, history pointer and key contents := 0.
- in_ready is 0 in IDLE and in DRAIN.
- Latency: a transfer at cycle n drives out_valid=1 with the result at n+1.
- Throughput: 1 symbol/cycle while out_ready = 1.
- With out_ready = 0, out_sym and out_valid hold. in_ready deasserts combinationally (the path is out_ready → in_ready), and no transfer is lost.
- key_len updates on the cycle after key_wr.
- start takes effect on the next edge. The first transfer is possible in the cycle after the state becomes RUN.

## Structure
- Package cipher_pkg holds:
  - mode encodings MODE_PASS, MODE_CAESAR, MODE_VIG, MODE_AUTO;
  - state encodings S_IDLE, S_RUN, S_DRAIN;
  - default ALPHA = 26.
- Sub-module cipher_mod_alu is a combinational modular add/subtract (in_sym, k, decode → out, in_range), parametrised by SYM_W and ALPHA.
- The key register file and autokey history are local flop arrays with no RAM inference.

## Test plan
- Caesar encode: key_wr 3, start mode=01 decode=0, stream 0, 1, 25 → out 3, 4, 2, each one cycle after acceptance.
- Vigenère round-trip:
  - Encode: key {1, 2, 3} with stream 0,0,0,0 → 1,2,3,1.
  - Decode: restart with decode=1; 1,2,3,1 → 0,0,0,0.
- Autokey encode: key {4}, stream 7, 4, 11 → out 11, 11, 15 (the keys used are 4, 7, 4).
- Backpressure: hold out_ready=0 for 3 cycles mid-stream → out_sym stable and in_ready=0; then release → no symbol dropped or duplicated.
- Errors:
  - key_wr 26 → err=1 and key_len unchanged.
  - start with mode 10 and an empty key → stays in IDLE.
  - in_sym 30 → out 30 and err=1.
- Drain and reset: stop with one output pending and out_ready=0 → state stays DRAIN. Raise out_ready → IDLE the next cycle. Assert reset during RUN → all outputs at reset values on the next edge.
